timing_control_gen: RTL and testbench

- Parametrised successor to the MSF timing controller.
- Counts MSF carrier pulses to derive a one-second marker, a second-of-minute counter and BRAM write strobes.
- Adds configurable widths, minute length and lane count, a carrier-loss holdover mode with a synthetic carrier, minute re-alignment and a low-time window output.
- Sits between the MSF carrier comparator/edge detector and the per-second/per-minute sample BRAMs.

---
 rtl/timing_control_gen.sv | 164 ++++++++++++++++
 tb/tb_timing_control_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/timing_control_gen.sv
// MSF timing controller: counts carrier pulses (or a synthetic carrier in holdover)
// into seconds and minutes and emits per-second/per-minute BRAM write strobes.
module timing_control_gen #(
  parameter int unsigned CNT_W         = 17,
  parameter int unsigned SEC_W         = 6,
  parameter int unsigned SECS_PER_MIN  = 60,
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned HOLDOVER_CLKS = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 msf_carrier_pulse,
  input  logic [CNT_W-1:0]     msf_frequency,
  input  logic [CNT_W-1:0]     low_time,
  input  logic [DIV_W-1:0]     holdover_div,
  input  logic                 minute_sync,
  output logic [CNT_W-1:0]     msf_carrier_counter,
  output logic                 one_sec_marker,
  output logic [SEC_W-1:0]     second_counter,
  output logic [NUM_LANES-1:0] write_second_bram,
  output logic [NUM_LANES-1:0] write_minute_bram,
  output logic                 low_window,
  output logic [1:0]           sync_state,
  output logic                 holdover_active
);

  localparam int unsigned WD_W = $clog2(HOLDOVER_CLKS + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(HOLDOVER_CLKS - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SECS_PER_MIN - 1);

  typedef enum logic [1:0] {
    ACQUIRE  = 2'd0,
    LOCKED   = 2'd1,
    HOLDOVER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEC_W-1:0]     sec_q, sec_d;
  logic                 marker_q, marker_d;
  logic [NUM_LANES-1:0] wsb_q, wsb_d;
  logic [NUM_LANES-1:0] wmb_q, wmb_d;
  logic                 pend_q, pend_d;

  logic                 tick;
  logic                 pend_eff;
  logic [SEC_W-1:0]     sec_new;
  logic [SEC_W-1:0]     lane_sel;
  logic [CNT_W-1:0]     freq;
  logic [DIV_W-1:0]     div_max;
  logic                 div_term;

  // Zero-valued divisor/frequency inputs are treated as 1
  assign freq     = (msf_frequency == '0) ? CNT_W'(1) : msf_frequency;
  assign div_max  = (holdover_div == '0) ? DIV_W'(1) : holdover_div;
  assign div_term = (div_q == div_max - DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACQUIRE;
      wd_q     <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      sec_q    <= '0;
      marker_q <= 1'b0;
      wsb_q    <= '0;
      wmb_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      sec_q    <= sec_d;
      marker_q <= marker_d;
      wsb_q    <= wsb_d;
      wmb_q    <= wmb_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    sec_d    = sec_q;
    marker_d = 1'b0;
    wsb_d    = '0;
    wmb_d    = '0;
    tick     = 1'b0;
    sec_new  = '0;
    lane_sel = '0;

    // Tick source selection and lock tracking
    case (state_q)
      ACQUIRE: begin
        if (msf_carrier_pulse) begin
          state_d = LOCKED;
          wd_d    = '0;
        end
      end
      LOCKED: begin
        tick = msf_carrier_pulse;
        if (msf_carrier_pulse) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          state_d = HOLDOVER;
          wd_d    = '0;
          div_d   = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      HOLDOVER: begin
        tick = msf_carrier_pulse | div_term;
        if (msf_carrier_pulse) begin
          state_d = LOCKED;
          wd_d    = '0;
          div_d   = '0;
        end else if (div_term) begin
          div_d = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ACQUIRE;
    endcase

    pend_eff = pend_q | (minute_sync && (state_q != ACQUIRE));
    pend_d   = pend_eff;

    // A counter at or beyond F-1 (e.g. after a frequency drop) closes the second
    if (tick) begin
      if (cnt_q >= freq - CNT_W'(1)) begin
        cnt_d    = '0;
        sec_new  = (pend_eff || (sec_q == SEC_LAST)) ? '0 : sec_q + SEC_W'(1);
        sec_d    = sec_new;
        marker_d = 1'b1;
        pend_d   = 1'b0;
        lane_sel = sec_new % SEC_W'(NUM_LANES);
        for (int i = 0; i < NUM_LANES; i++) begin
          wsb_d[i] = (lane_sel == SEC_W'(i));
        end
        wmb_d = (sec_new == '0) ? '1 : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign msf_carrier_counter = cnt_q;
  assign one_sec_marker      = marker_q;
  assign second_counter      = sec_q;
  assign write_second_bram   = wsb_q;
  assign write_minute_bram   = wmb_q;
  assign low_window          = (cnt_q < low_time);
  assign sync_state          = state_q;
  assign holdover_active     = (state_q == HOLDOVER);

endmodule

// File: tb/tb_timing_control_gen.sv
// Directed, table-driven bench for timing_control_gen with hand-written
// sequences for holdover, minute_sync, frequency change and mid-second reset.
module tb_timing_control_gen;

  localparam int unsigned CNT_W = 17;
  localparam int unsigned SEC_W = 6;
  localparam int unsigned NL    = 4;
  localparam int unsigned DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             msf_carrier_pulse;
  logic [CNT_W-1:0] msf_frequency;
  logic [CNT_W-1:0] low_time;
  logic [DIV_W-1:0] holdover_div;
  logic             minute_sync;
  logic [CNT_W-1:0] msf_carrier_counter;
  logic             one_sec_marker;
  logic [SEC_W-1:0] second_counter;
  logic [NL-1:0]    write_second_bram;
  logic [NL-1:0]    write_minute_bram;
  logic             low_window;
  logic [1:0]       sync_state;
  logic             holdover_active;

  int pass_cnt = 0;
  int total    = 0;

  timing_control_gen dut (
    .clk                 (clk),
    .rst                 (rst),
    .msf_carrier_pulse   (msf_carrier_pulse),
    .msf_frequency       (msf_frequency),
    .low_time            (low_time),
    .holdover_div        (holdover_div),
    .minute_sync         (minute_sync),
    .msf_carrier_counter (msf_carrier_counter),
    .one_sec_marker      (one_sec_marker),
    .second_counter      (second_counter),
    .write_second_bram   (write_second_bram),
    .write_minute_bram   (write_minute_bram),
    .low_window          (low_window),
    .sync_state          (sync_state),
    .holdover_active     (holdover_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pulses;
    int gap;
    int cnt;
    int sec;
    int mk;
    int wsb;
    int wmb;
    int low;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all(input string tag, input int cnt, input int sec, input int mk,
                           input int wsb, input int wmb, input int low, input int st);
    check({tag, ".counter"}, 32'(msf_carrier_counter), 32'(cnt));
    check({tag, ".second"},  32'(second_counter),      32'(sec));
    check({tag, ".marker"},  32'(one_sec_marker),      32'(mk));
    check({tag, ".wsb"},     32'(write_second_bram),   32'(wsb));
    check({tag, ".wmb"},     32'(write_minute_bram),   32'(wmb));
    check({tag, ".low"},     32'(low_window),          32'(low));
    check({tag, ".state"},   32'(sync_state),          32'(st));
    check({tag, ".hold"},    32'(holdover_active),     32'(st == 2));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse is sampled on the next posedge; returns at the following negedge
  task automatic send_pulse();
    msf_carrier_pulse = 1'b1;
    @(negedge clk);
    msf_carrier_pulse = 1'b0;
  endtask

  task automatic run(input int n, input int g);
    for (int i = 0; i < n; i++) begin
      send_pulse();
      if (i < n - 1) idle(g);
    end
  endtask

  initial begin
    rst               = 1'b1;
    msf_carrier_pulse = 1'b0;
    msf_frequency     = CNT_W'(10);
    low_time          = CNT_W'(3);
    holdover_div      = DIV_W'(165);
    minute_sync       = 1'b0;

    tbl[0]  = '{1,   164, 1, 0,  0, 4'b0000, 4'b0000, 1};
    tbl[1]  = '{1,   164, 2, 0,  0, 4'b0000, 4'b0000, 1};
    tbl[2]  = '{1,   164, 3, 0,  0, 4'b0000, 4'b0000, 0};
    tbl[3]  = '{6,   164, 9, 0,  0, 4'b0000, 4'b0000, 0};
    tbl[4]  = '{1,   164, 0, 1,  1, 4'b0010, 4'b0000, 1};
    tbl[5]  = '{10,  164, 0, 2,  1, 4'b0100, 4'b0000, 1};
    tbl[6]  = '{10,  164, 0, 3,  1, 4'b1000, 4'b0000, 1};
    tbl[7]  = '{10,  164, 0, 4,  1, 4'b0001, 4'b0000, 1};
    tbl[8]  = '{550, 1,   0, 59, 1, 4'b1000, 4'b0000, 1};
    tbl[9]  = '{10,  1,   0, 0,  1, 4'b0001, 4'b1111, 1};
    tbl[10] = '{1,   1,   1, 0,  0, 4'b0000, 4'b0000, 1};

    idle(1);
    check_all("reset", 0, 0, 0, 0, 0, 1, 0);
    rst = 1'b0;
    idle(2);
    check_all("acquire_hold", 0, 0, 0, 0, 0, 1, 0);

    send_pulse();
    check_all("lock", 0, 0, 0, 0, 0, 1, 1);
    idle(164);

    for (int r = 0; r < 11; r++) begin
      run(tbl[r].pulses, tbl[r].gap);
      check_all($sformatf("row%0d", r), tbl[r].cnt, tbl[r].sec, tbl[r].mk,
                tbl[r].wsb, tbl[r].wmb, tbl[r].low, 1);
      idle(tbl[r].gap);
    end

    // low_time = 0 keeps the window closed
    low_time = '0;
    #1;
    check("low_time0", 32'(low_window), 32'd0);
    low_time = CNT_W'(3);
    #1;

    // Carrier loss: holdover after 1024 clks, then synthetic ticks every 165 clks
    idle(1022);
    check("pre_hold.state", 32'(sync_state), 32'd1);
    idle(1);
    check_all("hold_entry", 1, 0, 0, 0, 0, 1, 2);
    idle(164);
    check("hold_no_tick", 32'(msf_carrier_counter), 32'd1);
    idle(1);
    check_all("hold_tick", 2, 0, 0, 0, 0, 1, 2);
    idle(164);
    send_pulse();
    check_all("resume_coincident", 3, 0, 0, 0, 0, 0, 1);

    // Advance to second 17, then minute_sync realigns the next boundary
    run(167, 1);
    check_all("sec17", 0, 17, 1, 4'b0010, 0, 1, 1);
    idle(1);
    minute_sync = 1'b1;
    @(negedge clk);
    minute_sync = 1'b0;
    run(9, 1);
    check("sync_wait.sec", 32'(second_counter), 32'd17);
    idle(1);
    send_pulse();
    check_all("sync_apply", 0, 0, 1, 4'b0001, 4'b1111, 1, 1);
    idle(1);
    check_all("strobe_1clk", 0, 0, 0, 0, 0, 1, 1);

    // minute_sync coincident with the boundary tick
    run(9, 1);
    idle(1);
    msf_carrier_pulse = 1'b1;
    minute_sync       = 1'b1;
    @(negedge clk);
    msf_carrier_pulse = 1'b0;
    minute_sync       = 1'b0;
    check_all("sync_same_cycle", 0, 0, 1, 4'b0001, 4'b1111, 1, 1);
    idle(1);
    run(10, 1);
    check_all("sync_cleared", 0, 1, 1, 4'b0010, 0, 1, 1);
    idle(1);

    // Lowered frequency forces a boundary on the next tick
    run(5, 1);
    check("pre_freq.counter", 32'(msf_carrier_counter), 32'd5);
    msf_frequency = CNT_W'(4);
    idle(1);
    send_pulse();
    check_all("freq_drop", 0, 2, 1, 4'b0100, 0, 1, 1);
    msf_frequency = CNT_W'(10);
    idle(1);

    // Asynchronous reset mid-second
    run(6, 1);
    check("pre_rst.counter", 32'(msf_carrier_counter), 32'd6);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    send_pulse();
    check_all("relock", 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    run(9, 1);
    check_all("relock_9", 9, 0, 0, 0, 0, 0, 1);
    idle(1);
    send_pulse();
    check_all("relock_sec", 0, 1, 1, 4'b0010, 0, 1, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
